alu_arbiter: RTL

- Shares one combinational ALU (32-bit entradaA/entradaB, 2-bit sel, 32-bit out) between two requesters, e.g. the integer pipeline and an address/branch unit.
- Uses a four-phase req/done handshake and round-robin arbitration.
- Latches the winning operands, drives the ALU for one cycle, then registers the result.
- The ALU is instantiated outside this block and connected through the alu_* ports.

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two
// requesters using a four-phase req/done handshake.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] entradaA0,
    input  logic [WIDTH-1:0] entradaB0,
    input  logic [SEL_W-1:0] sel0,
    input  logic             req1,
    input  logic [WIDTH-1:0] entradaA1,
    input  logic [WIDTH-1:0] entradaB1,
    input  logic [SEL_W-1:0] sel1,
    output logic [WIDTH-1:0] alu_entradaA,
    output logic [WIDTH-1:0] alu_entradaB,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] resultado,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             grant_id
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic             ultimo_reg, ultimo_next;
    logic             grant_reg, grant_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [1:0]       done_reg, done_next;

    logic [1:0]       req_vec;
    logic [1:0]       win_vec;
    logic [WIDTH-1:0] opa_arr [2];
    logic [WIDTH-1:0] opb_arr [2];
    logic [SEL_W-1:0] sel_arr [2];

    assign req_vec    = {req1, req0};
    assign opa_arr[0] = entradaA0;
    assign opa_arr[1] = entradaA1;
    assign opb_arr[0] = entradaB0;
    assign opb_arr[1] = entradaB1;
    assign sel_arr[0] = sel0;
    assign sel_arr[1] = sel1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            // A requester wins when alone, or on a tie when it was not the last one served.
            assign win_vec[gi] = req_vec[gi] & (~req_vec[1-gi] | (ultimo_reg != 1'(gi)));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        ultimo_next = ultimo_reg;
        grant_next  = grant_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        sel_next    = sel_reg;
        res_next    = res_reg;
        done_next   = done_reg;
        case (state_reg)
            IDLE: begin
                if (|win_vec) begin
                    grant_next  = win_vec[1];
                    ultimo_next = win_vec[1];
                    a_next      = opa_arr[win_vec[1]];
                    b_next      = opb_arr[win_vec[1]];
                    sel_next    = sel_arr[win_vec[1]];
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                res_next   = alu_out;
                done_next  = grant_reg ? 2'b10 : 2'b01;
                state_next = RESP;
            end
            RESP: begin
                // Hold the result until the served requester releases its request.
                if (!req_vec[grant_reg]) begin
                    done_next  = 2'b00;
                    state_next = IDLE;
                end
            end
            default: begin
                done_next  = 2'b00;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            ultimo_reg <= 1'b1;
            grant_reg  <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            sel_reg    <= '0;
            res_reg    <= '0;
            done_reg   <= 2'b00;
        end else begin
            state_reg  <= state_next;
            ultimo_reg <= ultimo_next;
            grant_reg  <= grant_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            sel_reg    <= sel_next;
            res_reg    <= res_next;
            done_reg   <= done_next;
        end
    end

    assign alu_entradaA = a_reg;
    assign alu_entradaB = b_reg;
    assign alu_sel      = sel_reg;
    assign resultado    = res_reg;
    assign done0        = done_reg[0];
    assign done1        = done_reg[1];
    assign grant_id     = grant_reg;
    assign busy         = (state_reg != IDLE);

endmodule
